// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send and
// shifts one command byte (LSB first, odd parity, stop) out on device clock edges.
// Ports: clock/reset (async, active high); tx_data/tx_start request, tx_busy/tx_done/
// tx_error status; ps2_clk_in/ps2_data_in raw lines; ps2_*_drive_low open-drain pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [9:0]    frame_q, frame_d;     // {stop, parity, data[7:0]}
  logic          clk_drv_q, clk_drv_d;
  logic          dat_drv_q, dat_drv_d;
  logic          err_q, err_d;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  logic          fe;

  // Synchronizers idle high so that reset release never looks like a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_data_in};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fe = clk_prev_q & ~clk_sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      clk_drv_q <= 1'b0;
      dat_drv_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      clk_drv_q <= clk_drv_d;
      dat_drv_q <= dat_drv_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    err_d     = err_q;
    cnt_inc   = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        if (tx_start) begin
          frame_d   = {1'b1, ~^tx_data, tx_data};
          err_d     = 1'b0;
          clk_drv_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_inc;
        if (cnt_q == INH_LAST) begin
          dat_drv_d = 1'b1;           // start bit
          state_d   = S_RTS;
        end
      end
      S_RTS: begin
        clk_drv_d = 1'b0;
        bit_idx_d = '0;
        cnt_d     = '0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (fe) begin
          // Only ever pull low; a 1 bit releases the line.
          dat_drv_d = ~frame_q[bit_idx_q];
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fe) begin
          if (dat_sync_q[1]) begin
            err_d     = 1'b1;
            clk_drv_d = 1'b0;
            dat_drv_d = 1'b0;
            state_d   = S_FINISH;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q[1] && dat_sync_q[1]) state_d = S_FINISH;
      end
      S_FINISH: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Device-clock watchdog: restarted by every falling edge, overrides any
    // transition above when it expires.
    if (state_q inside {S_SEND, S_ACK, S_WAIT_IDLE}) begin
      if (fe) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc;
        if (cnt_inc == TO_LIMIT) begin
          clk_drv_d = 1'b0;
          dat_drv_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_FINISH;
        end
      end
    end
  end

  assign tx_busy            = (state_q != S_IDLE);
  assign tx_done            = (state_q == S_FINISH);
  assign tx_error           = err_q;
  assign ps2_clk_drive_low  = clk_drv_q;
  assign ps2_data_drive_low = dat_drv_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  localparam int INH    = 40;
  localparam int TO     = 1500;
  localparam int HALF   = 20;
  localparam int BUDGET = 4000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, clk_drv, dat_drv;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  // Open-drain bus: low if either side pulls.
  assign ps2_clk_line  = ~(clk_drv | dev_clk_low);
  assign ps2_data_line = ~(dat_drv | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_drive_low(clk_drv), .ps2_data_drive_low(dat_drv)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  bit         chk_en = 1'b0;
  bit         dev_abort = 1'b0;
  bit         dev_active = 1'b0;
  bit         dev_high = 1'b0;
  int         dev_nfe = 0;
  logic [7:0] exp_byte = 8'h00;
  logic       exp_err = 1'b0;
  logic       prev_done = 1'b0;
  logic [9:0] rx;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Model: frame as the wire carries it, {stop, odd parity, data}.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // Expected host pull-low while the device holds the clock high after edge n.
  function automatic logic exp_drive(input int n, input logic [7:0] b);
    logic [9:0] f;
    f = frame_of(b);
    if (n == 0) return 1'b1;
    if (n <= 10) return ~f[n-1];
    return 1'b0;
  endfunction

  // Single compare process.
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      if (tx_done) begin
        check("done_err", 32'(tx_error), 32'(exp_err));
        check("done_drv", 32'({clk_drv, dat_drv}), 0);
        check("done_width", 32'(prev_done), 0);
        done_cnt++;
      end
      if (!tx_busy) check("idle_drv", 32'({clk_drv, dat_drv}), 0);
      if (dev_active && dev_high && dev_nfe <= 10) begin
        check("busy_send", 32'(tx_busy), 1);
        check("clk_rel", 32'(clk_drv), 0);
        check("bit", 32'(dat_drv), 32'(exp_drive(dev_nfe, exp_byte)));
      end
    end
    prev_done = tx_done;
  end

  task automatic dwait(input int n);
    for (int i = 0; i < n; i++) begin
      if (dev_abort) return;
      @(negedge clock);
    end
  endtask

  // Keyboard model: waits for request-to-send, then 11 clock pulses.
  task automatic device(input bit ack, output logic [9:0] r);
    int n = 0;
    r = '0;
    while (!(clk_drv == 1'b0 && dat_drv == 1'b1) && n < BUDGET && !dev_abort) begin
      @(negedge clock);
      n++;
    end
    if (n >= BUDGET) fail("dev_rts_wait");
    else if (!dev_abort) begin
      dev_nfe = 0;
      dev_high = 1'b1;
      dev_active = 1'b1;
      dwait(HALF);
      for (int k = 1; k <= 11; k++) begin
        if (dev_abort) break;
        dev_clk_low = 1'b1;
        dev_high = 1'b0;
        dev_nfe = k;
        dwait(HALF);
        if (dev_abort) break;
        dev_clk_low = 1'b0;
        dev_high = 1'b1;
        if (k <= 10) r[k-1] = ps2_data_line;
        dwait(HALF / 2);
        if (k == 10 && ack) dev_dat_low = 1'b1;
        dwait(HALF - HALF / 2);
      end
    end
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    dev_active = 1'b0;
    dev_high = 1'b0;
    dev_nfe = 0;
  endtask

  task automatic start_xfer(input logic [7:0] d);
    @(negedge clock);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (tx_busy && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    if (n >= BUDGET) fail(nm);
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_nfe(input int k, input string nm);
    int n = 0;
    while (dev_nfe < k && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    if (n >= BUDGET) fail(nm);
  endtask

  initial begin
    int n;
    int d0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_done", 32'(tx_done), 0);
    check("rst_err", 32'(tx_error), 0);
    check("rst_drv", 32'({clk_drv, dat_drv}), 0);
    reset = 1'b0;
    @(negedge clock);
    chk_en = 1'b1;

    // 0xED with ACK, plus exact inhibit/RTS timing.
    exp_byte = 8'hED; exp_err = 1'b0; d0 = done_cnt;
    start_xfer(8'hED);
    fork
      device(1'b1, rx);
      begin
        n = 0;
        while (clk_drv && !dat_drv && n < BUDGET) begin
          n++;
          @(negedge clock);
        end
        check("inhibit_len", 32'(n), INH);
        check("rts_both", 32'({clk_drv, dat_drv}), 32'h3);
        @(negedge clock);
        check("release", 32'({clk_drv, dat_drv}), 32'h1);
      end
    join
    wait_idle("ed_idle");
    check("ed_bits", 32'(rx), 32'h3ED);
    check("ed_done_cnt", 32'(done_cnt - d0), 1);
    check("ed_err", 32'(tx_error), 0);

    // 0x00 NACK; tx_start during FINISH must be ignored.
    exp_byte = 8'h00; exp_err = 1'b1; d0 = done_cnt;
    start_xfer(8'h00);
    fork
      device(1'b0, rx);
      begin
        n = 0;
        while (!tx_done && n < BUDGET) begin
          @(negedge clock);
          n++;
        end
        if (n >= BUDGET) fail("nack_done");
        tx_data = 8'h55;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        check("finish_start_ignored", 32'(tx_busy), 0);
        check("nack_err_held", 32'(tx_error), 1);
      end
    join
    wait_idle("nack_idle");
    check("nack_bits", 32'(rx), 32'h300);
    check("nack_done_cnt", 32'(done_cnt - d0), 1);
    repeat (20) @(negedge clock);
    check("err_still_held", 32'(tx_error), 1);

    // 0xF4 to a silent device: timeout.
    exp_byte = 8'hF4; exp_err = 1'b1; d0 = done_cnt;
    start_xfer(8'hF4);
    check("err_cleared_on_start", 32'(tx_error), 0);
    n = 0;
    while (!(clk_drv == 1'b0 && dat_drv == 1'b1) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    if (n >= BUDGET) fail("to_release");
    n = 0;
    while (!tx_done && n < TO + 100) begin
      @(negedge clock);
      n++;
    end
    check("timeout_len", 32'(n), TO);
    check("timeout_err", 32'(tx_error), 1);
    check("timeout_drv", 32'({clk_drv, dat_drv}), 0);
    @(negedge clock);
    check("timeout_busy_fall", 32'(tx_busy), 0);
    check("to_done_cnt", 32'(done_cnt - d0), 1);

    // 0xF4 again with a 0xFF request arriving mid-frame.
    exp_byte = 8'hF4; exp_err = 1'b0; d0 = done_cnt;
    start_xfer(8'hF4);
    fork
      device(1'b1, rx);
      begin
        wait_nfe(3, "f4_nfe3");
        @(negedge clock);
        tx_data = 8'hFF;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
      end
    join
    wait_idle("f4_idle");
    check("f4_bits", 32'(rx), 32'h2F4);
    check("f4_done_cnt", 32'(done_cnt - d0), 1);
    check("f4_err", 32'(tx_error), 0);

    // Asynchronous reset after the fourth device edge.
    exp_byte = 8'hED; exp_err = 1'b0;
    start_xfer(8'hED);
    fork
      device(1'b1, rx);
      begin
        wait_nfe(4, "rst_nfe4");
        repeat (5) @(negedge clock);
        #3;
        chk_en = 1'b0;
        dev_abort = 1'b1;
        reset = 1'b1;
        #1;
        check("async_rst_drv", 32'({clk_drv, dat_drv}), 0);
        check("async_rst_busy", 32'(tx_busy), 0);
      end
    join
    repeat (3) @(negedge clock);
    reset = 1'b0;
    dev_abort = 1'b0;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;

    // Normal 0xED after reset.
    d0 = done_cnt;
    start_xfer(8'hED);
    device(1'b1, rx);
    wait_idle("ed2_idle");
    check("ed2_bits", 32'(rx), 32'h3ED);
    check("ed2_done_cnt", 32'(done_cnt - d0), 1);
    check("ed2_err", 32'(tx_error), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
